// File: rtl/axi_lite_mem_slave_p.sv
// AXI4-Lite scratchpad slave: parametrised width/depth, WSTRB byte lanes, SLVERR on
// out-of-range addresses, single-entry AW/W holding registers. DATA_W must be 32 or 64.
module axi_lite_mem_slave_p #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned RNG_W  = $clog2(DEPTH);
  localparam int unsigned IDX_W  = (RNG_W > 0) ? RNG_W : 1;
  localparam logic [DATA_W-1:0] ERR_WORD    = DATA_W'(ERR_DATA);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  logic                init_q;
  logic                aw_full_q;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic                w_full_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [STRB_W-1:0]   w_strb_q;
  logic                bvalid_q;
  logic [1:0]          bresp_q;
  logic                rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          rresp_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                aw_hs;
  logic                w_hs;
  logic                ar_hs;
  logic                wr_commit;
  logic                aw_in_range;
  logic                ar_in_range;
  logic [IDX_W-1:0]    aw_idx;
  logic [IDX_W-1:0]    ar_idx;

  // READYs depend only on registered state, never on the VALIDs.
  assign AWREADY = init_q && !aw_full_q;
  assign WREADY  = init_q && !w_full_q;
  assign ARREADY = init_q && !rvalid_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  assign aw_hs     = AWVALID && AWREADY;
  assign w_hs      = WVALID && WREADY;
  assign ar_hs     = ARVALID && ARREADY;
  assign wr_commit = aw_full_q && w_full_q && !bvalid_q;

  // Range test covers every address bit above the word index, so aliases are rejected.
  assign aw_in_range = (aw_addr_q >> (LSB + RNG_W)) == '0;
  assign ar_in_range = (ARADDR >> (LSB + RNG_W)) == '0;
  assign aw_idx      = IDX_W'(aw_addr_q >> LSB);
  assign ar_idx      = IDX_W'(ARADDR >> LSB);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      init_q    <= 1'b0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      init_q <= 1'b1;

      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= AWADDR;
      end else if (wr_commit) begin
        aw_full_q <= 1'b0;
      end

      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end else if (wr_commit) begin
        w_full_q <= 1'b0;
      end

      if (wr_commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && BREADY) begin
        bvalid_q <= 1'b0;
      end

      // rvalid_q doubles as the read-busy flag.
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= ar_in_range ? mem_q[ar_idx] : ERR_WORD;
        rresp_q  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Storage is not reset; a read on the commit edge sees the old word.
  always_ff @(posedge ACLK) begin
    if (wr_commit && aw_in_range) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (w_strb_q[i]) mem_q[aw_idx][i*8 +: 8] <= w_data_q[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_slave_p.sv
// Scoreboard bench for axi_lite_mem_slave_p (DATA_W=32, DEPTH=256): directed scenarios
// followed by randomized traffic checked against a word-array reference model.
module tb_axi_lite_mem_slave_p;
  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b1;
  logic [31:0] AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [31:0] ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b0;

  always #5 ACLK = ~ACLK;

  axi_lite_mem_slave_p #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .DEPTH   (256),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          bp_rand  = 1'b0;
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  logic [31:0] mdl [256];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: 256 words, address/4 selects the word, anything at/above 0x400 errors.
  task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if ((a >> 2) < 256) begin
      for (int b = 0; b < 4; b++) if (s[b]) mdl[a >> 2][b*8 +: 8] = d[b*8 +: 8];
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(2'b10);
    end
  endtask

  task automatic expect_read(input logic [31:0] a);
    if ((a >> 2) < 256) exp_r.push_back({2'b00, mdl[a >> 2]});
    else                exp_r.push_back({2'b10, 32'hDEAD_BEEF});
  endtask

  task automatic send_aw(input logic [31:0] a);
    bit ok = 1'b0;
    AWADDR = a; AWVALID = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin @(negedge ACLK); ok = AWREADY; end
    chk("awready_wait", ok, 1);
    @(posedge ACLK); #1; AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 1'b0;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin @(negedge ACLK); ok = WREADY; end
    chk("wready_wait", ok, 1);
    @(posedge ACLK); #1; WVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    bit ok = 1'b0;
    ARADDR = a; ARVALID = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin @(negedge ACLK); ok = ARREADY; end
    chk("arready_wait", ok, 1);
    @(posedge ACLK); #1; ARVALID = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int da, input int dw);
    expect_write(a, d, s);
    fork
      begin repeat (da) begin @(posedge ACLK); #1; end send_aw(a); end
      begin repeat (dw) begin @(posedge ACLK); #1; end send_w(d, s); end
    join
  endtask

  task automatic do_read(input logic [31:0] a);
    expect_read(a);
    send_ar(a);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 300) begin
      @(negedge ACLK); n++;
    end
    chk("drain_timeout", (n >= 300), 0);
    exp_b.delete(); exp_r.delete();
    @(posedge ACLK); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k = $urandom_range(0, 23);
    logic [31:0] a;
    if (k >= 20) begin
      a = $urandom;
      if (a < 32'h400) a += 32'h400;
      return a;
    end
    return ((k < 16) ? k : k + 236) * 4 + $urandom_range(0, 3);
  endfunction

  // Randomised back-pressure on B/R while enabled.
  initial forever begin
    @(posedge ACLK); #1;
    if (bp_rand) begin
      BREADY = ($urandom_range(0, 3) != 0);
      RREADY = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks hold-stability.
  initial begin : monitor
    bit          b_hold, r_hold;
    logic [1:0]  b_prev;
    logic [33:0] r_prev;
    b_hold = 1'b0; r_hold = 1'b0; b_prev = '0; r_prev = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        b_hold = 1'b0; r_hold = 1'b0;
      end else begin
        if (b_hold) chk("b_stable", {BVALID, BRESP}, {1'b1, b_prev});
        b_hold = 1'b0;
        if (BVALID) begin
          if (BREADY) begin
            if (exp_b.size() == 0) chk("b_unexpected", BVALID, 0);
            else chk("bresp", BRESP, exp_b.pop_front());
          end else begin
            b_hold = 1'b1; b_prev = BRESP;
          end
        end
        if (r_hold) chk("r_stable", {RVALID, RRESP, RDATA}, {1'b1, r_prev});
        r_hold = 1'b0;
        if (RVALID) begin
          if (RREADY) begin
            if (exp_r.size() == 0) chk("r_unexpected", RVALID, 0);
            else chk("rresp_rdata", {RRESP, RDATA}, exp_r.pop_front());
          end else begin
            r_hold = 1'b1; r_prev = {RRESP, RDATA};
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] wa, ra, wd;
    int unsigned op;

    // Reset and init flag
    #2 ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_flags", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, 0);
    chk("reset_rdata", RDATA, 0);
    @(posedge ACLK); #1; ARESETn = 1'b1;
    @(negedge ACLK);
    chk("ready_before_init", {AWREADY, WREADY, ARREADY}, 0);
    @(negedge ACLK);
    chk("ready_after_init", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b11100);

    // Aligned write/read with latency checks
    @(posedge ACLK); #1;
    BREADY = 1'b1; RREADY = 1'b1;
    expect_write(32'h10, 32'hA5A5_1234, 4'hF);
    AWADDR = 32'h10; WDATA = 32'hA5A5_1234; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge ACLK); chk("t2_ready", {AWREADY, WREADY}, 2'b11);
    @(posedge ACLK); #1; AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK); chk("t2_bvalid_early", BVALID, 0);
    @(negedge ACLK); chk("t2_bvalid_lat", BVALID, 1);
    @(posedge ACLK); #1;
    expect_read(32'h10);
    ARADDR = 32'h10; ARVALID = 1'b1;
    @(negedge ACLK); chk("t2_arready", ARREADY, 1);
    @(posedge ACLK); #1; ARVALID = 1'b0;
    @(negedge ACLK); chk("t2_rvalid_lat", RVALID, 1);
    @(negedge ACLK); chk("t2_arready_back", {RVALID, ARREADY}, 2'b01);
    @(posedge ACLK); #1;
    drain();

    // Byte strobe merge
    do_write(32'h10, 32'h0000_FF00, 4'b0010, 0, 0); drain();
    do_read(32'h10); drain();

    // Prefill the words used by random traffic
    bp_rand = 1'b1;
    for (int k = 0; k < 20; k++) begin
      do_write(((k < 16) ? k : k + 236) * 4, $urandom, 4'hF, 0, 0);
      drain();
    end

    // W before AW under B back-pressure
    bp_rand = 1'b0; BREADY = 1'b0; RREADY = 1'b1;
    @(posedge ACLK); #1;
    expect_write(32'h20, 32'h1357_9BDF, 4'hF);
    WDATA = 32'h1357_9BDF; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK); chk("t4_wready", WREADY, 1);
    @(posedge ACLK); #1; WVALID = 1'b0;
    repeat (3) begin @(negedge ACLK); chk("t4_w_full", WREADY, 0); @(posedge ACLK); #1; end
    AWADDR = 32'h20; AWVALID = 1'b1;
    @(negedge ACLK); chk("t4_awready", {AWREADY, WREADY}, 2'b10);
    @(posedge ACLK); #1; AWVALID = 1'b0;
    @(negedge ACLK); chk("t4_pre_commit", {WREADY, BVALID}, 2'b00);
    @(negedge ACLK); chk("t4_commit", {AWREADY, WREADY, BVALID}, 3'b111);
    @(posedge ACLK); #1;
    expect_write(32'h24, 32'h2468_ACE0, 4'hF);
    AWADDR = 32'h24; WDATA = 32'h2468_ACE0; AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge ACLK); chk("t4_second_accept", {AWREADY, WREADY}, 2'b11);
    @(posedge ACLK); #1; AWVALID = 1'b0; WVALID = 1'b0;
    repeat (4) begin @(negedge ACLK); chk("t4_backpressure", {AWREADY, WREADY, BVALID}, 3'b001); end
    @(posedge ACLK); #1; BREADY = 1'b1;
    drain();
    do_read(32'h20); do_read(32'h24); drain();

    // Out-of-range and top-of-memory
    do_write(32'h400, 32'hCAFE_F00D, 4'hF, 0, 0); drain();
    do_read(32'h400); do_read(32'h3FC); do_read(32'h0); drain();

    // Read on the same edge as a commit to the same word
    do_write(32'h8, 32'h11, 4'hF, 0, 0); drain();
    expect_read(32'h8);
    expect_write(32'h8, 32'h22, 4'hF);
    AWADDR = 32'h8; WDATA = 32'h22; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge ACLK); chk("t6_aw_w_ready", {AWREADY, WREADY}, 2'b11);
    @(posedge ACLK); #1; AWVALID = 1'b0; WVALID = 1'b0; ARADDR = 32'h8; ARVALID = 1'b1;
    @(negedge ACLK); chk("t6_arready", ARREADY, 1);
    @(posedge ACLK); #1; ARVALID = 1'b0;
    drain();
    do_read(32'h8); drain();

    // Reset with an address held but no data: the held address must be dropped
    send_aw(32'h30);
    @(negedge ACLK); ARESETn = 1'b0;
    #1 chk("reset_async", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 0);
    @(posedge ACLK); #1; ARESETn = 1'b1;
    expect_write(32'h34, 32'h0BAD_0BAD, 4'hF);
    send_w(32'h0BAD_0BAD, 4'hF);
    repeat (3) begin @(negedge ACLK); chk("t7_no_commit", BVALID, 0); end
    @(posedge ACLK); #1;
    send_aw(32'h34); drain();
    do_read(32'h30); do_read(32'h34); drain();

    // Randomised traffic
    bp_rand = 1'b1;
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 3);
      wa = rand_addr();
      ra = rand_addr();
      wd = $urandom;
      case (op)
        0, 1: do_write(wa, wd, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
        2:    do_read(ra);
        default: begin
          while ((ra >> 2) == (wa >> 2)) ra = rand_addr();
          expect_read(ra);
          fork
            do_write(wa, wd, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
            send_ar(ra);
          join
        end
      endcase
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
